// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, issues word fetches, and buffers
// returned instructions in an in-order FIFO toward decode.
// A request is issued only while there is guaranteed room for its response,
// so the FIFO cannot overflow. A redirect flushes the buffered instructions
// and marks every in-flight response to be dropped.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [6:0]  if_opcode
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   pc;
  logic [31:0]   fifo_instr [FIFO_DEPTH];
  logic [31:0]   fifo_pc    [FIFO_DEPTH];
  logic [AW-1:0] fifo_head, fifo_tail;
  logic [CW-1:0] fifo_count;
  logic [31:0]   tag_pc     [FIFO_DEPTH];
  logic [AW-1:0] tag_head, tag_tail;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;

  logic [CW:0]   credit_used;
  logic          req_fire;
  logic          rsp_drop;
  logic          fifo_push;
  logic          fifo_pop;

  // Credit is taken from registered counts only; a same-cycle pop does not free a slot.
  assign credit_used    = {1'b0, outstanding} + {1'b0, fifo_count};
  assign imem_req_valid = rst_n && !redirect_valid && (credit_used < (CW+1)'(FIFO_DEPTH));
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_drop       = imem_rsp_valid && (drop_cnt != CW'(0));
  assign fifo_push      = imem_rsp_valid && !rsp_drop && !redirect_valid;
  assign fifo_pop       = (fifo_count != CW'(0)) && if_ready && !redirect_valid;

  // Head fields come straight from storage; zero while in reset or empty.
  assign if_valid  = rst_n && (fifo_count != CW'(0));
  assign if_instr  = if_valid ? fifo_instr[fifo_head] : 32'h0;
  assign if_pc     = if_valid ? fifo_pc[fifo_head]    : 32'h0;
  assign if_opcode = if_instr[6:0];

  // PC, pointers and counters; a redirect flushes and turns all in-flight fetches into drops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= RESET_PC & ~32'h3;
      fifo_head   <= '0;
      fifo_tail   <= '0;
      fifo_count  <= '0;
      tag_head    <= '0;
      tag_tail    <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (redirect_valid) begin
      pc          <= redirect_pc & ~32'h3;
      fifo_head   <= '0;
      fifo_tail   <= '0;
      fifo_count  <= '0;
      tag_head    <= '0;
      tag_tail    <= '0;
      outstanding <= outstanding - CW'(imem_rsp_valid);
      drop_cnt    <= outstanding - CW'(imem_rsp_valid);
    end else begin
      if (req_fire) begin
        pc       <= pc + 32'd4;
        tag_tail <= tag_tail + AW'(1);
      end
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
      if (rsp_drop) begin
        drop_cnt <= drop_cnt - CW'(1);
      end
      if (imem_rsp_valid && !rsp_drop) begin
        tag_head <= tag_head + AW'(1);
      end
      if (fifo_push) begin
        fifo_tail <= fifo_tail + AW'(1);
      end
      if (fifo_pop) begin
        fifo_head <= fifo_head + AW'(1);
      end
      fifo_count <= fifo_count + CW'(fifo_push) - CW'(fifo_pop);
    end
  end

  // Data storage needs no reset; validity is tracked by the counters above.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      tag_pc[tag_tail] <= pc;
    end
    if (fifo_push) begin
      fifo_instr[fifo_tail] <= imem_rsp_data;
      fifo_pc[fifo_tail]    <= tag_pc[tag_head];
    end
  end

  // The credit scheme must make a push into a full, non-popping FIFO impossible.
  always_ff @(posedge clk) begin
    if (rst_n && fifo_push && !fifo_pop) begin
      assert (fifo_count != CW'(FIFO_DEPTH));
    end
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front-end stage directly upstream of control_unit: owns the PC, issues word fetches to instruction memory and buffers returned instructions in a small in-order FIFO.
- Presents each instruction with its PC and opcode slice to decode over a valid/ready handshake.
- Accepts branch/jump redirects from execute, flushing buffered and in-flight fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
- FIFO_DEPTH, 4, instruction buffer entries; power of two, ≥2.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  reset; one clock; reset is synchronous and active-low.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_req_addr  output  32  word-aligned fetch address (= PC).
- imem_rsp_valid  input  1  response valid; responses return in request order, ≥1 cycle after acceptance, never back-pressured.
- imem_rsp_data  input  32  fetched instruction.
- redirect_valid  input  1  taken branch/jump; 1-cycle pulse.
- redirect_pc  input  32  new PC; bits [1:0] ignored (forced 0).
- if_valid  output  1  instruction available to decode.
- if_ready  input  1  decode accepts.
- if_instr  output  32  instruction at FIFO head.
- if_pc  output  32  PC of that instruction.
- if_opcode  output  7  if_instr[6:0], feeds control_unit opcode.

Behaviour:
- Reset (rst_n=0 at edge): pc=RESET_PC, FIFO empty, outstanding=0, drop_cnt=0. While rst_n=0: imem_req_valid=0, if_valid=0; if_instr/if_pc/if_opcode=0. First request in first cycle with rst_n=1. Reset mid-operation discards everything; responses to pre-reset requests are the memory's problem (memory is reset with the same rst_n).
- Request: imem_req_valid=1 iff rst_n=1, redirect_valid=0 and outstanding+fifo_count < FIFO_DEPTH (registered counts, no same-cycle pop credit). imem_req_addr=pc. On valid&ready: pc<=pc+4 (mod 2^32, wraps 0xFFFF_FFFC→0), outstanding+1, request's PC pushed to a tag queue (depth FIFO_DEPTH). Request may drop if ready=0 and credit lost or redirect arrives.
- Response: outstanding−1; pop tag queue. If drop_cnt>0: drop_cnt−1, data discarded. Else write {data, tag PC} to FIFO tail. Credit scheme guarantees no overflow; overflow is an assertion failure.
- Output: if_valid = fifo_count>0; head fields driven from registered FIFO storage; no response→output bypass (response at cycle N visible at earliest cycle N+1). Pop on if_valid&if_ready.
- Redirect (redirect_valid=1 at edge): pc<=redirect_pc&~3; FIFO cleared; tag queue cleared; drop_cnt<=outstanding minus any response arriving that cycle (that response also dropped); no request issued that cycle; simultaneous decode pop ignored (flush wins); if_valid=0 next cycle. Back-to-back redirects: last wins, drop_cnt accumulates correctly.
- Simultaneous push and pop with FIFO full is impossible by credit; push+pop at count 1 keeps count 1.
- Throughput: 1 instruction/cycle with 1-cycle memory, imem_req_ready=1, if_ready=1.
- Latency: request at cycle 0, response at cycle 1 → if_valid at cycle 2.

Test Plan:
- Reset release, 1-cycle memory, if_ready=1 → addrs 0x0,0x4,0x8…; if_pc sequence identical, first if_valid 2 cycles after first request, then every cycle.
- if_ready=0 for 10 cycles → exactly 4 instructions held in FIFO, imem_req_valid=0 once outstanding+count=4; on release PCs 0x0..0xC delivered in order, no loss/duplication.
- 3-cycle memory latency with 2 outstanding, redirect_pc=0x100 → old responses discarded, next if_pc=0x100 with its data; imem_req_addr=0x100 first cycle after redirect.
- Redirect with redirect_pc=0x203 in the same cycle as a response and a decode pop → pc=0x200, response dropped, if_valid=0 next cycle.
- pc at 0xFFFF_FFF8 → fetches 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- rst_n=0 mid-stream with FIFO full → next cycle if_valid=0, outputs 0; after release fetch restarts at RESET_PC.
